// File: rtl/dual_rail_pkg.sv
// dual_rail_pkg: shared definitions for the dual-rail precharge receiver
// and related dual-rail checkers.
//   - per-bit rail codes ({t,f} pairs)
//   - word classification enum
//   - receiver FSM state enum
//   - Err_code values
package dual_rail_pkg;

    // Per-bit code, packed as {true_rail, false_rail}
    localparam logic [1:0] DR_PRE  = 2'b00;
    localparam logic [1:0] DR_ZERO = 2'b01;
    localparam logic [1:0] DR_ONE  = 2'b10;
    localparam logic [1:0] DR_ILL  = 2'b11;

    // Whole-word class, evaluated in priority order ILL > PRE > EVAL > MIX
    typedef enum logic [1:0] {
        WC_PRE  = 2'd0,
        WC_EVAL = 2'd1,
        WC_MIX  = 2'd2,
        WC_ILL  = 2'd3
    } word_cls_e;

    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_EVAL_SEEN = 2'd2
    } rx_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_DBL_EVAL = 2'd1;
    localparam logic [1:0] ERR_MIX      = 2'd2;
    localparam logic [1:0] ERR_ILL      = 2'd3;

endpackage

// File: rtl/dual_rail_rx_if.sv
// dual_rail_rx_if: bundle between a dual-rail precharge stage and the
// single-rail consumer.
//   Din_t/Din_f : true/false rails (WIDTH bits each), from the dual-rail side
//   Dout        : decoded word
//   Valid       : one-cycle strobe, Dout is new
//   Err         : one-cycle protocol-violation strobe
//   Err_code    : cause of last Err (sticky)
//   Synced      : receiver is armed / tracking alternation
//   Err_cnt     : saturating error count (only with DR_ERR_CNT_EN)
// Modports: master = rail driver / result consumer, slave = receiver.
interface dual_rail_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Din_t;
    logic [WIDTH-1:0] Din_f;
    logic [WIDTH-1:0] Dout;
    logic             Valid;
    logic             Err;
    logic [1:0]       Err_code;
    logic             Synced;
`ifdef DR_ERR_CNT_EN
    logic [15:0]      Err_cnt;

    modport master (output Din_t, Din_f,
                    input  Dout, Valid, Err, Err_code, Synced, Err_cnt);
    modport slave  (input  Din_t, Din_f,
                    output Dout, Valid, Err, Err_code, Synced, Err_cnt);
`else
    modport master (output Din_t, Din_f,
                    input  Dout, Valid, Err, Err_code, Synced);
    modport slave  (input  Din_t, Din_f,
                    output Dout, Valid, Err, Err_code, Synced);
`endif
endinterface

// File: rtl/dual_rail_classify.sv
// dual_rail_classify: combinational word classifier for a dual-rail word.
//   in_t, in_f : true/false rails (WIDTH bits)
//   cls        : WC_ILL if any bit is 11, else WC_PRE if all bits 00,
//                else WC_EVAL if every bit is 01/10, else WC_MIX.
module dual_rail_classify
    import dual_rail_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_f,
    output word_cls_e        cls
);

    logic any_ill;
    logic all_pre;
    logic all_eval;

    always_comb begin
        any_ill  = 1'b0;
        all_pre  = 1'b1;
        all_eval = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            case ({in_t[i], in_f[i]})
                DR_PRE:  all_eval = 1'b0;
                DR_ILL: begin
                    any_ill  = 1'b1;
                    all_pre  = 1'b0;
                    all_eval = 1'b0;
                end
                default: all_pre = 1'b0;   // DR_ZERO / DR_ONE
            endcase
        end
    end

    always_comb begin
        if (any_ill)       cls = WC_ILL;
        else if (all_pre)  cls = WC_PRE;
        else if (all_eval) cls = WC_EVAL;
        else               cls = WC_MIX;
    end

endmodule

// File: rtl/dual_rail_rx.sv
// dual_rail_rx: dual-rail precharge receiver. Registers the rails, classifies
// the word, enforces PRE/EVAL alternation and converts EVAL words to
// single-rail data with a Valid strobe. Protocol violations (illegal codes,
// partially evaluated words, missing precharge) raise Err with a cause code.
//   CLK    : clock, rising edge
//   Reset  : asynchronous, active-high
//   dr     : dual_rail_rx_if.slave (rails in, Dout/Valid/Err/Err_code/Synced out)
// Optional: define DR_ERR_CNT_EN to add the 16-bit saturating Err_cnt output.
// Latency: word on Din at edge k -> Dout/Valid/Err after edge k+1.
module dual_rail_rx
    import dual_rail_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRE_MIN = 1    // 1..15
) (
    input  logic          CLK,
    input  logic          Reset,
    dual_rail_rx_if.slave dr
);

    localparam logic [3:0] PRE_MIN_4 = 4'(PRE_MIN);

    // Stage 1: raw rails; reset to all-precharge
    logic [WIDTH-1:0] in_t_q, in_f_q;

    word_cls_e        cls;

    rx_state_e        state_q, state_d;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [3:0]       pre_cnt_inc;

    dual_rail_classify #(.WIDTH(WIDTH)) u_classify (
        .in_t (in_t_q),
        .in_f (in_f_q),
        .cls  (cls)
    );

    assign pre_cnt_inc = (pre_cnt_q == 4'd15) ? 4'd15 : pre_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        unique case (state_q)
            ST_SYNC: begin
                // Silent while hunting for a clean precharge run
                if (cls == WC_PRE) begin
                    if (pre_cnt_inc >= PRE_MIN_4) begin
                        state_d   = ST_ARMED;
                        pre_cnt_d = 4'd0;
                    end else begin
                        pre_cnt_d = pre_cnt_inc;
                    end
                end else begin
                    pre_cnt_d = 4'd0;
                end
            end
            ST_ARMED: begin
                unique case (cls)
                    WC_PRE: ;
                    WC_EVAL: begin
                        dout_d  = in_t_q;
                        valid_d = 1'b1;
                        state_d = ST_EVAL_SEEN;
                    end
                    WC_MIX: begin
                        err_d      = 1'b1;
                        err_code_d = ERR_MIX;
                        state_d    = ST_SYNC;
                    end
                    default: begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILL;
                        state_d    = ST_SYNC;
                    end
                endcase
            end
            ST_EVAL_SEEN: begin
                unique case (cls)
                    WC_PRE: state_d = ST_ARMED;
                    WC_EVAL: begin
                        // Second evaluate without precharge in between
                        err_d      = 1'b1;
                        err_code_d = ERR_DBL_EVAL;
                        state_d    = ST_SYNC;
                    end
                    WC_MIX: begin
                        err_d      = 1'b1;
                        err_code_d = ERR_MIX;
                        state_d    = ST_SYNC;
                    end
                    default: begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILL;
                        state_d    = ST_SYNC;
                    end
                endcase
            end
            default: begin
                state_d   = ST_SYNC;
                pre_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            in_t_q     <= '0;
            in_f_q     <= '0;
            state_q    <= ST_SYNC;
            pre_cnt_q  <= 4'd0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            in_t_q     <= dr.Din_t;
            in_f_q     <= dr.Din_f;
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign dr.Dout     = dout_q;
    assign dr.Valid    = valid_q;
    assign dr.Err      = err_q;
    assign dr.Err_code = err_code_q;
    assign dr.Synced   = (state_q != ST_SYNC);

`ifdef DR_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) err_cnt_q <= 16'd0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign dr.Err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dual_rail_rx.sv
// tb_dual_rail_rx: directed self-checking bench for dual_rail_rx.
// Two instances: u_dut1 (PRE_MIN=1) and u_dut3 (PRE_MIN=3), shared clock/reset.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_dual_rail_rx;

    logic CLK;
    logic Reset;
    int   n_vec;
    int   n_err;

    dual_rail_rx_if #(.WIDTH(8)) if1 ();
    dual_rail_rx_if #(.WIDTH(8)) if3 ();

    dual_rail_rx #(.WIDTH(8), .PRE_MIN(1)) u_dut1 (
        .CLK   (CLK),
        .Reset (Reset),
        .dr    (if1.slave)
    );

    dual_rail_rx #(.WIDTH(8), .PRE_MIN(3)) u_dut3 (
        .CLK   (CLK),
        .Reset (Reset),
        .dr    (if3.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Apply a rail pair to the selected DUT, then let one edge capture it.
    task automatic drive(input int which, input logic [7:0] t, input logic [7:0] f);
        if (which == 1) begin
            if1.Din_t = t;
            if1.Din_f = f;
        end else begin
            if3.Din_t = t;
            if3.Din_f = f;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic pre(input int which);
        drive(which, 8'h00, 8'h00);
    endtask

    task automatic eval(input int which, input logic [7:0] v);
        drive(which, v, ~v);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        if1.Din_t = 8'h00; if1.Din_f = 8'h00;
        if3.Din_t = 8'h00; if3.Din_f = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        n_vec++;
        if ({if1.Dout, if1.Valid, if1.Err, if1.Err_code, if1.Synced} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got dout=%h v=%b e=%b code=%0d s=%b want all 0",
                     if1.Dout, if1.Valid, if1.Err, if1.Err_code, if1.Synced);
        end
`ifdef DR_ERR_CNT_EN
        n_vec++;
        if (if1.Err_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_err_cnt: got %0d want 0", if1.Err_cnt);
        end
`endif
        Reset = 1'b0;
        // Stage 1 holds PRE from reset, so the first edge arms the receiver.
        pre(1);
        n_vec++;
        if (if1.Synced !== 1'b1) begin
            n_err++;
            $display("FAIL reset_arm_synced: got %b want 1", if1.Synced);
        end
    endtask

    task automatic test_alternate;
        eval(1, 8'hA5);
        n_vec++;
        if (if1.Valid !== 1'b0) begin
            n_err++;
            $display("FAIL alt_novalid_pre: got %b want 0", if1.Valid);
        end
        pre(1);
        n_vec++;
        if (if1.Valid !== 1'b1 || if1.Dout !== 8'hA5 || if1.Err !== 1'b0) begin
            n_err++;
            $display("FAIL alt_a5: got v=%b dout=%h e=%b want v=1 dout=a5 e=0",
                     if1.Valid, if1.Dout, if1.Err);
        end
        eval(1, 8'h3C);
        n_vec++;
        if (if1.Valid !== 1'b0 || if1.Err !== 1'b0) begin
            n_err++;
            $display("FAIL alt_gap: got v=%b e=%b want v=0 e=0", if1.Valid, if1.Err);
        end
        pre(1);
        n_vec++;
        if (if1.Valid !== 1'b1 || if1.Dout !== 8'h3C || if1.Err !== 1'b0) begin
            n_err++;
            $display("FAIL alt_3c: got v=%b dout=%h e=%b want v=1 dout=3c e=0",
                     if1.Valid, if1.Dout, if1.Err);
        end
        pre(1);
        n_vec++;
        if (if1.Valid !== 1'b0 || if1.Err !== 1'b0 || if1.Dout !== 8'h3C) begin
            n_err++;
            $display("FAIL alt_tail: got v=%b e=%b dout=%h want v=0 e=0 dout=3c",
                     if1.Valid, if1.Err, if1.Dout);
        end
    endtask

    task automatic test_double_eval;
        eval(1, 8'h11);
        eval(1, 8'h22);
        n_vec++;
        if (if1.Valid !== 1'b1 || if1.Dout !== 8'h11) begin
            n_err++;
            $display("FAIL dbl_first: got v=%b dout=%h want v=1 dout=11", if1.Valid, if1.Dout);
        end
        pre(1);
        n_vec++;
        if (if1.Err !== 1'b1 || if1.Err_code !== 2'd1 || if1.Valid !== 1'b0
            || if1.Dout !== 8'h11) begin
            n_err++;
            $display("FAIL dbl_err: got e=%b code=%0d v=%b dout=%h want e=1 code=1 v=0 dout=11",
                     if1.Err, if1.Err_code, if1.Valid, if1.Dout);
        end
        n_vec++;
        if (if1.Synced !== 1'b0) begin
            n_err++;
            $display("FAIL dbl_synced_drop: got %b want 0", if1.Synced);
        end
        pre(1);
        n_vec++;
        if (if1.Synced !== 1'b1 || if1.Err !== 1'b0 || if1.Err_code !== 2'd1) begin
            n_err++;
            $display("FAIL dbl_rearm: got s=%b e=%b code=%0d want s=1 e=0 code=1",
                     if1.Synced, if1.Err, if1.Err_code);
        end
    endtask

    task automatic test_illegal;
        // 0xF0 evaluate with bit 3 forced to 11
        drive(1, 8'hF8, 8'h0F);
        pre(1);
        n_vec++;
        if (if1.Err !== 1'b1 || if1.Err_code !== 2'd3 || if1.Valid !== 1'b0) begin
            n_err++;
            $display("FAIL ill_err: got e=%b code=%0d v=%b want e=1 code=3 v=0",
                     if1.Err, if1.Err_code, if1.Valid);
        end
        n_vec++;
        if (if1.Synced !== 1'b0 || if1.Dout !== 8'h11) begin
            n_err++;
            $display("FAIL ill_sync: got s=%b dout=%h want s=0 dout=11", if1.Synced, if1.Dout);
        end
        pre(1);
    endtask

    task automatic test_mixed;
        // bits[7:4] evaluated (1010), bits[3:0] still precharged
        drive(1, 8'hA0, 8'h50);
        pre(1);
        n_vec++;
        if (if1.Err !== 1'b1 || if1.Err_code !== 2'd2 || if1.Valid !== 1'b0) begin
            n_err++;
            $display("FAIL mix_err: got e=%b code=%0d v=%b want e=1 code=2 v=0",
                     if1.Err, if1.Err_code, if1.Valid);
        end
        pre(1);
`ifdef DR_ERR_CNT_EN
        n_vec++;
        if (if1.Err_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL err_cnt_three: got %0d want 3", if1.Err_cnt);
        end
`endif
    endtask

    task automatic test_reset_midflight;
        eval(1, 8'h77);
        // EVAL sits in stage 1; reset before the edge that would report it
        Reset = 1'b1;
        #1;
        n_vec++;
        if ({if1.Dout, if1.Valid, if1.Err, if1.Err_code, if1.Synced} !== 13'd0) begin
            n_err++;
            $display("FAIL mid_reset_clear: got dout=%h v=%b e=%b code=%0d s=%b want all 0",
                     if1.Dout, if1.Valid, if1.Err, if1.Err_code, if1.Synced);
        end
`ifdef DR_ERR_CNT_EN
        n_vec++;
        if (if1.Err_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset_err_cnt: got %0d want 0", if1.Err_cnt);
        end
`endif
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        pre(1);
        pre(1);
        n_vec++;
        if (if1.Valid !== 1'b0 || if1.Err !== 1'b0 || if1.Dout !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset_dropped: got v=%b e=%b dout=%h want v=0 e=0 dout=00",
                     if1.Valid, if1.Err, if1.Dout);
        end
    endtask

    task automatic test_pre_min3;
        Reset = 1'b1;
        if3.Din_t = 8'h00; if3.Din_f = 8'hFF;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        eval(3, 8'h00);   // clears the count left by the reset-PRE
        pre(3);
        pre(3);
        eval(3, 8'h99);   // only 2 PREs before this evaluate
        pre(3);
        n_vec++;
        if (if3.Valid !== 1'b0 || if3.Err !== 1'b0 || if3.Synced !== 1'b0) begin
            n_err++;
            $display("FAIL pm3_ignored: got v=%b e=%b s=%b want v=0 e=0 s=0",
                     if3.Valid, if3.Err, if3.Synced);
        end
        pre(3);
        pre(3);
        eval(3, 8'h5A);
        n_vec++;
        if (if3.Synced !== 1'b1 || if3.Valid !== 1'b0) begin
            n_err++;
            $display("FAIL pm3_armed: got s=%b v=%b want s=1 v=0", if3.Synced, if3.Valid);
        end
        pre(3);
        n_vec++;
        if (if3.Valid !== 1'b1 || if3.Dout !== 8'h5A || if3.Err !== 1'b0) begin
            n_err++;
            $display("FAIL pm3_valid: got v=%b dout=%h e=%b want v=1 dout=5a e=0",
                     if3.Valid, if3.Dout, if3.Err);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_alternate();
        test_double_eval();
        test_illegal();
        test_mixed();
        test_reset_midflight();
        test_pre_min3();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dual_rail_rx.md
# dual_rail_rx

Dual-rail precharge receiver: accepts a WIDTH-bit word on true/false rails from a dual-rail precharge DFF stage and converts it back to single-rail data with a one-cycle valid strobe. It enforces the precharge/evaluate alternation. It detects illegal codes, partially evaluated words and missing precharge phases as fault-injection indicators. It sits at the boundary where the hardened AES datapath hands results to non-hardened logic (output register, key-schedule readback).

## Interface
- WIDTH, 8: rail width in bits (per rail).
- PRE_MIN, 1: consecutive all-precharge cycles required in SYNC before arming (1..15).
- CLK  in  1  clock; all flops rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Din_t  in  WIDTH  true rail.
- Din_f  in  WIDTH  false rail.
- Dout  out  WIDTH  decoded single-rail word (true-rail value).
- Valid  out  1  one-cycle strobe; Dout is new this cycle.
- Err  out  1  one-cycle strobe; protocol violation detected.
- Err_code  out  2  cause of last Err: 0 none, 1 double-evaluate, 2 mixed word, 3 illegal 11 code; holds until next Err or Reset.
- Synced  out  1  high while FSM is in ARMED or EVAL_SEEN.
- Err_cnt  out  16  saturating error count; present only with DR_ERR_CNT_EN.

## Operation
- Per-bit code: 00 precharge, 10 logic 1 (t=1,f=0), 01 logic 0, 11 illegal.
- Stage 1: Din_t/Din_f registered every cycle into in_t/in_f; reset value 00 on all bits.
- Word class, combinational on stage-1 registers, priority order: ILL (any bit 11) > PRE (all bits 00) > EVAL (all bits 01/10) > MIX (remaining: some 00, some valid).
- FSM states: SYNC, ARMED, EVAL_SEEN. Reset state SYNC.
- SYNC: pre_cnt increments on PRE and clears on any other class; go to ARMED when pre_cnt reaches PRE_MIN. Errors are not reported in SYNC; Valid stays 0.
- ARMED (last accepted word was precharge): PRE stays; EVAL loads Dout <= in_t, pulses Valid, goes to EVAL_SEEN; MIX or ILL raises Err and goes to SYNC.
- EVAL_SEEN: PRE goes to ARMED; EVAL raises Err with code 1 (double-evaluate, missing precharge), Dout not updated, goes to SYNC; MIX raises Err code 2 and goes to SYNC; ILL raises Err code 3 and goes to SYNC.
- Any error leaves Dout at its previous value; Valid and Err never assert together.
- pre_cnt is 4 bits and saturates at 15; it clears on leaving SYNC.

## Timing
- Reset values: Dout 0, Valid 0, Err 0, Err_code 0, Synced 0, Err_cnt 0, in_t/in_f 0, FSM SYNC, pre_cnt 0.
- Latency: a word present on Din at edge k appears on Dout/Valid (or Err) after edge k+1, i.e. 2 edges.
- Stage-1 reset value is PRE. With PRE_MIN=1, the FSM reaches ARMED at the first edge after Reset deasserts, provided no non-PRE word is in stage 1. Synced rises the cycle after that edge.
- Throughput: at most one Valid every 2 cycles (PRE/EVAL alternation).
- Reset asserted mid-operation: all state clears immediately and asynchronously; an in-flight word is dropped; no Valid or Err is issued for it.

## Configuration
- DR_ERR_CNT_EN defined: Err_cnt port and a 16-bit counter are present. The counter increments on each Err and saturates at 16'hFFFF; Reset clears it.
- Not defined: no counter logic and no Err_cnt port. All other behaviour is identical.

## Structure
- Package dual_rail_pkg holds: code constants (DR_PRE=2'b00, DR_ZERO=2'b01, DR_ONE=2'b10, DR_ILL=2'b11), word-class enum (PRE, EVAL, MIX, ILL), FSM state enum, and Err_code constants.
- Sub-module dual_rail_classify (combinational, parameter WIDTH): in_t/in_f in, word class out. It is reused by other dual-rail checkers.

## Test plan
- Reset, then alternate PRE / EVAL 8'hA5 / PRE / EVAL 8'h3C, with WIDTH=8 and PRE_MIN=1. Required: Valid pulses 2 edges after each EVAL, Dout=A5 then 3C, Err never asserts.
- PRE, EVAL 8'h11, EVAL 8'h22. Required: Valid for 11, then Err with Err_code=1, Dout stays 11, Synced drops; the next PRE re-arms.
- Bit 3 driven 11 during EVAL. Required: Err with Err_code=3, no Valid, FSM enters SYNC.
- Word with bits[3:0] 00 and bits[7:4] valid after PRE. Required: Err with Err_code=2.
- PRE_MIN=3: send 2 PRE then EVAL. Required: ignored, no Valid, no Err. Then send 3 PRE then EVAL 8'h5A. Required: Valid with Dout=5A.
- Assert Reset on the cycle between EVAL input and its Valid. Required: no Valid, all outputs 0. With DR_ERR_CNT_EN, force 3 errors beforehand. Required: Err_cnt=3 before Reset and 0 after.
